// File: rtl/sc_countdown_arbiter.sv
// sc_countdown_arbiter
// Two-requester round-robin arbiter that owns a single 3-bit countdown.
// A winning request loads the counter from its own load bus. The counter then
// decrements once every TICK_DIV cycles until it reaches zero, and the owner
// is told via one-cycle grant and done pulses. Requests are only looked at
// while the block is idle, so an active countdown can never be pre-empted.

module sc_countdown_arbiter #(
    parameter int TICK_DIV  = 4,   // RUN cycles per decrement, legal 1..16
    parameter int DATAWIDTH = 3    // count width, fixed at 3 for this block
) (
    input  logic                 SC_COUNTDOWN_ARBITER_CLOCK_50,
    input  logic                 SC_COUNTDOWN_ARBITER_RESET_InHigh,
    input  logic                 SC_COUNTDOWN_ARBITER_req0_In,
    input  logic                 SC_COUNTDOWN_ARBITER_req1_In,
    input  logic [DATAWIDTH-1:0] SC_COUNTDOWN_ARBITER_load0_InBUS,
    input  logic [DATAWIDTH-1:0] SC_COUNTDOWN_ARBITER_load1_InBUS,
    output logic                 SC_COUNTDOWN_ARBITER_grant0_Out,
    output logic                 SC_COUNTDOWN_ARBITER_grant1_Out,
    output logic                 SC_COUNTDOWN_ARBITER_done0_Out,
    output logic                 SC_COUNTDOWN_ARBITER_done1_Out,
    output logic                 SC_COUNTDOWN_ARBITER_busy_Out,
    output logic [DATAWIDTH-1:0] SC_COUNTDOWN_ARBITER_count_OutBUS,
    output logic                 SC_COUNTDOWN_ARBITER_zero_OutLow
);

    // The prescaler only has to reach TICK_DIV-1 <= 15.
    localparam int PRESCALE_W = 4;
    localparam logic [PRESCALE_W-1:0] PRESCALE_LAST = PRESCALE_W'(TICK_DIV - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } stateT;

    stateT                 state;
    logic [DATAWIDTH-1:0]  count;
    logic [PRESCALE_W-1:0] prescaler;
    logic                  owner;       // requester that holds the countdown
    logic                  lastServed;  // round-robin pointer
    logic                  grant0;
    logic                  grant1;
    logic                  done0;
    logic                  done1;
    logic                  busy;

    logic                  anyReq;
    logic                  winner;
    logic [DATAWIDTH-1:0]  winnerLoad;

    // Arbitration: a lone request wins outright; on a tie the requester that
    // was not served most recently wins.
    always_comb begin
        // NOTE: every always_comb output gets a default first, so no path can
        // leave it unassigned and infer a latch.
        winner = 1'b0;
        if (SC_COUNTDOWN_ARBITER_req0_In && SC_COUNTDOWN_ARBITER_req1_In) begin
            winner = ~lastServed;
        end else if (SC_COUNTDOWN_ARBITER_req1_In) begin
            winner = 1'b1;
        end
    end

    assign anyReq     = SC_COUNTDOWN_ARBITER_req0_In | SC_COUNTDOWN_ARBITER_req1_In;
    assign winnerLoad = winner ? SC_COUNTDOWN_ARBITER_load1_InBUS
                               : SC_COUNTDOWN_ARBITER_load0_InBUS;

    // Control FSM with counter, prescaler and registered pulse outputs.
    always_ff @(posedge SC_COUNTDOWN_ARBITER_CLOCK_50) begin
        // NOTE: state registers use non-blocking assignments so every flop
        // samples pre-edge values, independent of statement order.
        if (SC_COUNTDOWN_ARBITER_RESET_InHigh) begin
            state      <= IDLE;
            count      <= '0;
            prescaler  <= '0;
            owner      <= 1'b0;
            lastServed <= 1'b1;
            grant0     <= 1'b0;
            grant1     <= 1'b0;
            done0      <= 1'b0;
            done1      <= 1'b0;
            busy       <= 1'b0;
        end else begin
            // Pulses last one cycle unless a branch below re-asserts them.
            grant0 <= 1'b0;
            grant1 <= 1'b0;
            done0  <= 1'b0;
            done1  <= 1'b0;

            case (state)
                IDLE: begin
                    if (anyReq) begin
                        count     <= winnerLoad;
                        prescaler <= '0;
                        owner     <= winner;
                        grant0    <= ~winner;
                        grant1    <= winner;
                        busy      <= 1'b1;
                        if (winnerLoad == '0) begin
                            // Nothing to count: grant and done coincide.
                            state <= DONE;
                            done0 <= ~winner;
                            done1 <= winner;
                        end else begin
                            state <= RUN;
                        end
                    end
                end

                RUN: begin
                    if (prescaler == PRESCALE_LAST) begin
                        prescaler <= '0;
                        if (count != '0) begin
                            count <= count - 1'b1;
                        end
                        // The decrement that reaches zero ends the run.
                        if (count <= DATAWIDTH'(1)) begin
                            state <= DONE;
                            done0 <= ~owner;
                            done1 <= owner;
                        end
                    end else begin
                        prescaler <= prescaler + 1'b1;
                    end
                end

                DONE: begin
                    lastServed <= owner;
                    busy       <= 1'b0;
                    state      <= IDLE;
                end

                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    assign SC_COUNTDOWN_ARBITER_grant0_Out   = grant0;
    assign SC_COUNTDOWN_ARBITER_grant1_Out   = grant1;
    assign SC_COUNTDOWN_ARBITER_done0_Out    = done0;
    assign SC_COUNTDOWN_ARBITER_done1_Out    = done1;
    assign SC_COUNTDOWN_ARBITER_busy_Out     = busy;
    assign SC_COUNTDOWN_ARBITER_count_OutBUS = count;
    assign SC_COUNTDOWN_ARBITER_zero_OutLow  = (count != '0);

endmodule

// File: tb/tb_sc_countdown_arbiter.sv
// tb_sc_countdown_arbiter
// Cycle-by-cycle vector table for reset, tie arbitration and zero load, then
// hand-written sequences for single request, maximum load with a mid-run load
// change, and reset in the middle of a countdown.

module tb_sc_countdown_arbiter;

    localparam int TD = 4;

    logic       clk;
    logic       rst;
    logic       req0;
    logic       req1;
    logic [2:0] load0;
    logic [2:0] load1;
    logic       grant0;
    logic       grant1;
    logic       done0;
    logic       done1;
    logic       busy;
    logic [2:0] count;
    logic       zeroLow;

    int checks = 0;
    int fails  = 0;

    typedef struct {
        logic       rst;
        logic       r0;
        logic       r1;
        logic [2:0] l0;
        logic [2:0] l1;
        logic [8:0] exp;   // {grant0, grant1, done0, done1, busy, count, zeroLow}
    } vecT;

    vecT vecs[$];

    sc_countdown_arbiter #(
        .TICK_DIV (TD),
        .DATAWIDTH(3)
    ) dut (
        .SC_COUNTDOWN_ARBITER_CLOCK_50    (clk),
        .SC_COUNTDOWN_ARBITER_RESET_InHigh(rst),
        .SC_COUNTDOWN_ARBITER_req0_In     (req0),
        .SC_COUNTDOWN_ARBITER_req1_In     (req1),
        .SC_COUNTDOWN_ARBITER_load0_InBUS (load0),
        .SC_COUNTDOWN_ARBITER_load1_InBUS (load1),
        .SC_COUNTDOWN_ARBITER_grant0_Out  (grant0),
        .SC_COUNTDOWN_ARBITER_grant1_Out  (grant1),
        .SC_COUNTDOWN_ARBITER_done0_Out   (done0),
        .SC_COUNTDOWN_ARBITER_done1_Out   (done1),
        .SC_COUNTDOWN_ARBITER_busy_Out    (busy),
        .SC_COUNTDOWN_ARBITER_count_OutBUS(count),
        .SC_COUNTDOWN_ARBITER_zero_OutLow (zeroLow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [8:0] pack(logic g0, logic g1, logic d0, logic d1,
                                        logic b, logic [2:0] c, logic zl);
        return {g0, g1, d0, d1, b, c, zl};
    endfunction

    task automatic add(int n, logic r, logic r0, logic r1, logic [2:0] l0,
                       logic [2:0] l1, logic [8:0] exp);
        vecT v;
        v.rst = r; v.r0 = r0; v.r1 = r1; v.l0 = l0; v.l1 = l1; v.exp = exp;
        for (int i = 0; i < n; i++) vecs.push_back(v);
    endtask

    task automatic check(string name, logic [8:0] act, logic [8:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got g0g1d0d1/busy/count/zl=%b expected %b", name, act, exp);
        end
    endtask

    // One clock edge; outputs are sampled 1 ns after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [8:0] outs();
        return {grant0, grant1, done0, done1, busy, count, zeroLow};
    endfunction

    initial begin
        logic [2:0] c;
        rst = 1'b1; req0 = 1'b0; req1 = 1'b0; load0 = '0; load1 = '0;

        // Reset held 2 cycles with a tie already pending, then tie handling.
        add(2,  1, 1, 1, 3'd1, 3'd2, pack(0, 0, 0, 0, 0, 3'd0, 0));
        add(1,  0, 1, 1, 3'd1, 3'd2, pack(1, 0, 0, 0, 1, 3'd1, 1));
        add(3,  0, 1, 1, 3'd1, 3'd2, pack(0, 0, 0, 0, 1, 3'd1, 1));
        add(1,  0, 1, 1, 3'd1, 3'd2, pack(0, 0, 1, 0, 1, 3'd0, 0));
        add(1,  0, 1, 1, 3'd1, 3'd2, pack(0, 0, 0, 0, 0, 3'd0, 0));
        add(1,  0, 1, 1, 3'd1, 3'd2, pack(0, 1, 0, 0, 1, 3'd2, 1));
        add(3,  0, 1, 1, 3'd1, 3'd2, pack(0, 0, 0, 0, 1, 3'd2, 1));
        add(4,  0, 1, 1, 3'd1, 3'd2, pack(0, 0, 0, 0, 1, 3'd1, 1));
        add(1,  0, 1, 1, 3'd1, 3'd2, pack(0, 0, 0, 1, 1, 3'd0, 0));
        add(1,  0, 1, 1, 3'd1, 3'd2, pack(0, 0, 0, 0, 0, 3'd0, 0));
        add(1,  0, 1, 1, 3'd1, 3'd2, pack(1, 0, 0, 0, 1, 3'd1, 1));
        // Reset, then zero load on requester 1.
        add(1,  1, 0, 0, 3'd0, 3'd0, pack(0, 0, 0, 0, 0, 3'd0, 0));
        add(1,  0, 0, 1, 3'd0, 3'd0, pack(0, 1, 0, 1, 1, 3'd0, 0));
        add(2,  0, 0, 0, 3'd0, 3'd0, pack(0, 0, 0, 0, 0, 3'd0, 0));

        foreach (vecs[i]) begin
            rst = vecs[i].rst; req0 = vecs[i].r0; req1 = vecs[i].r1;
            load0 = vecs[i].l0; load1 = vecs[i].l1;
            step();
            check($sformatf("vec%0d", i), outs(), vecs[i].exp);
        end

        // Single request, load 3: count changes every TD cycles, done 12 later.
        req0 = 1'b1; load0 = 3'd3;
        step();
        check("single_grant", outs(), pack(1, 0, 0, 0, 1, 3'd3, 1));
        req0 = 1'b0; load0 = 3'd0;
        for (int k = 1; k <= 3 * TD; k++) begin
            step();
            c = 3'(3 - k / TD);
            check($sformatf("single_k%0d", k), outs(),
                  pack(0, 0, k == 3 * TD, 0, 1, c, c != 0));
        end
        step();
        check("single_idle", outs(), pack(0, 0, 0, 0, 0, 3'd0, 0));

        // Maximum load 7; load bus changes mid-run must be ignored.
        req0 = 1'b1; load0 = 3'd7;
        step();
        check("max_grant", outs(), pack(1, 0, 0, 0, 1, 3'd7, 1));
        req0 = 1'b0;
        for (int k = 1; k <= 7 * TD; k++) begin
            if (k == 10) load0 = 3'd2;
            step();
            c = 3'(7 - k / TD);
            check($sformatf("max_k%0d", k), outs(),
                  pack(0, 0, k == 7 * TD, 0, 1, c, c != 0));
        end
        step();
        check("max_idle", outs(), pack(0, 0, 0, 0, 0, 3'd0, 0));

        // Requester 0 was served last, so this tie goes to requester 1.
        req0 = 1'b1; req1 = 1'b1; load0 = 3'd5; load1 = 3'd3;
        step();
        check("abort_grant1", outs(), pack(0, 1, 0, 0, 1, 3'd3, 1));
        for (int k = 1; k <= TD; k++) begin
            step();
            c = 3'(3 - k / TD);
            check($sformatf("abort_k%0d", k), outs(), pack(0, 0, 0, 0, 1, c, 1));
        end
        // Reset at count 2: idle, count 0, no done; pointer back to 1.
        rst = 1'b1;
        step();
        check("abort_reset", outs(), pack(0, 0, 0, 0, 0, 3'd0, 0));
        rst = 1'b0;
        step();
        check("abort_next_tie", outs(), pack(1, 0, 0, 0, 1, 3'd5, 1));
        req0 = 1'b0; req1 = 1'b0;
        step();
        check("abort_run", outs(), pack(0, 0, 0, 0, 1, 3'd5, 1));

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
